// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared constants and types for the shared-bus interconnect slice.
//   - state_t        : interconnect FSM states (ST_IDLE, ST_BUSY, ST_DECERR)
//   - NUM_SLAVES     : number of downstream slaves
//   - DECERR_DATA    : read data returned with an error beat
//   - SLV_*          : slave index constants matching the address map
//   - slave_word()   : extract one slave's 32-bit word from the packed bus
//   - slave_onehot() : turn a slave index into a one-hot select vector
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int          NUM_SLAVES  = 4;
    localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] SLV_RAM   = 2'd0;
    localparam logic [1:0] SLV_UART  = 2'd1;
    localparam logic [1:0] SLV_TIMER = 2'd2;
    localparam logic [1:0] SLV_SPARE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_DECERR = 2'd2
    } state_t;

    function automatic logic [31:0] slave_word(input logic [NUM_SLAVES*32-1:0] data,
                                               input logic [1:0]               idx);
        return data[{idx, 5'd0} +: 32];
    endfunction

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [1:0] idx);
        return NUM_SLAVES'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_if.sv
// ---------------------------------------------------------------------------
// bus_if
// Upstream request/response channel between the arbiter and the interconnect.
//   bus_addr/bus_wdata/bus_wstrb/bus_write/bus_enable : request (arbiter drives)
//   bus_rdata/bus_ready/bus_error                     : response (interconnect drives)
// Modports:
//   master : arbiter side
//   slave  : interconnect side
// ---------------------------------------------------------------------------
interface bus_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_write;
    logic        bus_enable;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_error;

    modport master (
        output bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable,
        input  bus_rdata, bus_ready, bus_error
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable,
        output bus_rdata, bus_ready, bus_error
    );

endinterface

// File: rtl/bus_addr_decoder.sv
// ---------------------------------------------------------------------------
// bus_addr_decoder
// Purely combinational address decoder for the four slave windows.
// A window hits when (addr & MASK) == BASE; if several windows hit, the
// lowest slave index wins.
// Ports:
//   addr in  32 : request address
//   sel  out 2  : selected slave index (SLV_RAM when no hit)
//   hit  out 1  : 1 when any window matched
// ---------------------------------------------------------------------------
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE = 32'h4000_1000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S3_BASE = 32'h4000_2000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_F000
) (
    input  logic [31:0] addr,
    output logic [1:0]  sel,
    output logic        hit
);

    // Priority chain gives the lowest-index window precedence on overlap.
    always_comb begin
        sel = SLV_RAM;
        hit = 1'b1;
        if ((addr & S0_MASK) == S0_BASE) begin
            sel = SLV_RAM;
        end else if ((addr & S1_MASK) == S1_BASE) begin
            sel = SLV_UART;
        end else if ((addr & S2_MASK) == S2_BASE) begin
            sel = SLV_TIMER;
        end else if ((addr & S3_MASK) == S3_BASE) begin
            sel = SLV_SPARE;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
// Shared-bus fabric behind the two-master arbiter. Decodes the arbitrated
// request to one of four slaves, locks the selection for the life of a
// transaction, and answers unmapped addresses with a decode-error beat.
// Requests that hit are forwarded in the same cycle (no added latency).
//
// Optional feature: define BUS_TIMEOUT_EN to add a per-transaction watchdog
// that forces an error completion after TIMEOUT_CYCLES busy cycles.
//
// Ports:
//   clk       in   1   : clock
//   rst_n     in   1   : asynchronous active-low reset
//   bus       slave    : upstream channel (bus_if.slave)
//   s_addr    out  32  : broadcast address
//   s_wdata   out  32  : broadcast write data
//   s_wstrb   out  4   : broadcast byte strobes
//   s_write   out  1   : broadcast write flag
//   s_enable  out  4   : one-hot slave select
//   s_rdata   in   128 : slave k read data in [32k+31:32k]
//   s_ready   in   4   : slave k ready in bit k
// ---------------------------------------------------------------------------
module bus_interconnect
    import bus_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE = 32'h4000_1000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S3_BASE = 32'h4000_2000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_F000
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bus_if.slave                       bus,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    output logic                       s_write,
    output logic [NUM_SLAVES-1:0]      s_enable,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready
);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  dec_sel;
    logic        dec_hit;

    logic [NUM_SLAVES-1:0] enable_c;
    logic                  ready_c;
    logic                  error_c;
    logic [31:0]           rdata_c;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    bus_addr_decoder #(
        .S0_BASE (S0_BASE), .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE), .S1_MASK (S1_MASK),
        .S2_BASE (S2_BASE), .S2_MASK (S2_MASK),
        .S3_BASE (S3_BASE), .S3_MASK (S3_MASK)
    ) u_decoder (
        .addr (bus.bus_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign s_addr  = bus.bus_addr;
    assign s_wdata = bus.bus_wdata;
    assign s_wstrb = bus.bus_wstrb;
    assign s_write = bus.bus_write;

    assign s_enable      = enable_c;
    assign bus.bus_ready = ready_c;
    assign bus.bus_error = error_c;
    assign bus.bus_rdata = rdata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SLV_RAM;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        enable_c = '0;
        ready_c  = 1'b0;
        error_c  = 1'b0;
        rdata_c  = '0;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.bus_enable) begin
                    if (dec_hit) begin
                        // Fresh decode drives the slave select combinationally,
                        // so a ready slave completes in this same cycle.
                        enable_c = slave_onehot(dec_sel);
                        ready_c  = s_ready[dec_sel];
                        if (s_ready[dec_sel]) begin
                            rdata_c = slave_word(s_rdata, dec_sel);
                        end else begin
                            state_d = ST_BUSY;
                            sel_d   = dec_sel;
`ifdef BUS_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else begin
                        state_d = ST_DECERR;
                    end
                end
            end

            ST_BUSY: begin
                // Routing is locked to sel_q; the live address is ignored.
                if (!bus.bus_enable) begin
                    state_d = ST_IDLE;
                end else if (s_ready[sel_q]) begin
                    enable_c = slave_onehot(sel_q);
                    ready_c  = 1'b1;
                    rdata_c  = slave_word(s_rdata, sel_q);
                    state_d  = ST_IDLE;
`ifdef BUS_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry: deselect the slave and report an error.
                    ready_c = 1'b1;
                    error_c = 1'b1;
                    rdata_c = DECERR_DATA;
                    state_d = ST_IDLE;
                end else begin
                    enable_c = slave_onehot(sel_q);
                    cnt_d    = cnt_q + CNT_W'(1);
`else
                end else begin
                    enable_c = slave_onehot(sel_q);
`endif
                end
            end

            ST_DECERR: begin
                if (bus.bus_enable) begin
                    ready_c = 1'b1;
                    error_c = 1'b1;
                    rdata_c = DECERR_DATA;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While reset is held, IDLE decode must not re-select a slave, so
        // all outputs are forced quiet independent of the request inputs.
        if (!rst_n) begin
            enable_c = '0;
            ready_c  = 1'b0;
            error_c  = 1'b0;
            rdata_c  = '0;
        end
    end

endmodule
